multicycle_chunk_adder: RTL and testbench
=========================================

// Module: multicycle_chunk_adder
// PURPOSE
//  Parametrised multi-cycle adder/subtractor for the datapath ALU.
//  Adds or subtracts two WIDTH-bit operands CHUNK bits per clock through a
//  CHUNK-bit ripple-carry slice, holding the inter-chunk carry in a register.
//  Uses a start/done handshake and reports carry, overflow and zero flags.
//  Trades latency (WIDTH/CHUNK cycles) for a short ripple critical path.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK    8  bits added per cycle (1..WIDTH); NCHUNK = WIDTH/CHUNK (localparam)
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      request; sampled only when busy==0
//  op_sub  in   1      0: a+b, 1: a-b; latched with start
//  a       in   WIDTH  operand A; latched with start
//  b       in   WIDTH  operand B; latched with start
//  busy    out  1      high while chunks are being processed
//  done    out  1      one-cycle pulse; result outputs are valid from this cycle on
//  sum     out  WIDTH  result, updated only when done rises
//  cout    out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf     out  1      signed overflow = carry into MSB ^ carry out of MSB
//  zero    out  1      sum == 0
// BEHAVIOUR
//  - States: IDLE, BUSY, DONE. rst forces IDLE, idx=0, carry reg=0.
//    rst also forces busy=done=cout=ovf=zero=0 and sum=0, asynchronously.
//  - Acceptance: start=1 at a rising edge while in IDLE or DONE.
//    That edge latches a, b^{WIDTH{op_sub}} and op_sub.
//    Carry reg <= op_sub, idx <= 0, state -> BUSY.
//  - BUSY: each edge adds chunk idx of A and B' plus the carry reg.
//    Writes the CHUNK result bits into the internal result reg.
//    Carry reg <= chunk carry-out, idx++.
//    On the edge with idx==NCHUNK-1 it also:
//    sum <= full result, cout <= final carry, ovf <= c_in_msb ^ c_out_msb,
//    zero <= (result==0), state -> DONE.
//  - Latency: done is high in the cycle after NCHUNK edges following the
//    accepting edge. CHUNK==WIDTH gives done one edge after acceptance.
//  - DONE lasts exactly one cycle and asserts done=1, busy=0.
//    If start=1 at that edge, a new op is accepted (back-to-back, no bubble).
//    Otherwise the state goes to IDLE.
//  - busy=1 iff state==BUSY. start while BUSY is ignored. Latched operands
//    are unaffected by a, b or op_sub changes after acceptance.
//  - sum/cout/ovf/zero hold their last values until the next done.
//    They never show partial results.
//  - Arithmetic is modulo 2^WIDTH; sub is two's complement (A + ~B + 1).
//  - Reset mid-operation aborts it: no done pulse, outputs return to
//    reset values.
// STRUCTURE
//  - Shared package alu_pkg: OP_ADD=1'b0 / OP_SUB=1'b1 constants and the
//    state encoding typedef (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
//  - Sub-module ripple_slice #(CHUNK): combinational CHUNK-bit ripple chain of
//    full adders (a, b, cin -> s, cout). It also exposes the carry into its
//    MSB, which gives ovf on the last chunk.
//  - Top level: FSM, idx counter ($clog2(NCHUNK) bits, min 1), operand and
//    result registers, flag logic.
// TESTING
//  - WIDTH=32,CHUNK=8: add 0xFFFFFFFF+0x1 -> sum=0, cout=1, ovf=0, zero=1;
//    done 4 edges after accept.
//  - sub 5-7 -> sum=0xFFFFFFFE, cout=0, ovf=0, zero=0; sub 7-5 -> sum=2,
//    cout=1.
//  - add 0x7FFFFFFF+0x1 -> sum=0x80000000, ovf=1, cout=0; sub
//    0x80000000-1 -> ovf=1.
//  - start re-pulsed with new operands while busy -> ignored, first result
//    returned. start held in the done cycle -> second op accepted, its done
//    follows 4 edges later.
//  - rst raised in the 2nd BUSY cycle -> all outputs 0, no done. The next op
//    (3+4) -> sum=7.
//  - WIDTH=4,CHUNK=4: 0xF+0x1 -> sum=0, cout=1, done 1 edge after accept.
//    WIDTH=4,CHUNK=1: same result after 4 edges.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode constants and the chunk-adder state encoding
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_slice.sv
// rtl/ripple_slice.sv - CHUNK-bit combinational ripple-carry chain of full adders
module ripple_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[CHUNK];
  // Carry into the top bit; on the last chunk this pairs with cout for signed overflow.
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/multicycle_chunk_adder.sv
// rtl/multicycle_chunk_adder.sv - multi-cycle add/sub, CHUNK bits per clock with start/done handshake
module multicycle_chunk_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_r, b_r, res_r, res_next;
  logic             carry_r;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] cs;
  logic             cc, cm;
  logic             accept, step, last;

  ripple_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (a_r[idx*CHUNK +: CHUNK]),
    .b    (b_r[idx*CHUNK +: CHUNK]),
    .cin  (carry_r),
    .s    (cs),
    .cout (cc),
    .cmsb (cm)
  );

  assign accept = start && (state != BUSY);
  assign step   = (state == BUSY);
  assign last   = (idx == IW'(NCHUNK - 1));

  always_comb begin
    res_next = res_r;
    res_next[idx*CHUNK +: CHUNK] = cs;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_n = BUSY;
      BUSY: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = start ? BUSY : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B here, seed the carry with the opcode.
      a_r     <= a;
      b_r     <= b ^ {WIDTH{op_sub == OP_SUB}};
      carry_r <= (op_sub == OP_SUB);
      idx     <= '0;
    end else if (step) begin
      res_r   <= res_next;
      carry_r <= cc;
      idx     <= idx + 1'b1;
      if (last) begin
        sum  <= res_next;
        cout <= cc;
        ovf  <= cc ^ cm;
        zero <= (res_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// tb/tb_multicycle_chunk_adder.sv - self-checking bench with behavioural model and directed vectors
module tb_multicycle_chunk_adder;

  localparam int W   = 32;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0, op_sub = 1'b0;
  logic [W-1:0]  a = '0, b = '0;
  logic          busy, done, cout, ovf, zero;
  logic [W-1:0]  sum;

  logic          s_start = 1'b0;
  logic [3:0]    s_a = '0, s_b = '0;
  logic          b44, d44, co44, ov44, z44, b41, d41, co41, ov41, z41;
  logic [3:0]    sum44, sum41;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

  multicycle_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut44 (
    .clk(clk), .rst(rst), .start(s_start), .op_sub(1'b0), .a(s_a), .b(s_b),
    .busy(b44), .done(d44), .sum(sum44), .cout(co44), .ovf(ov44), .zero(z44));

  multicycle_chunk_adder #(.WIDTH(4), .CHUNK(1)) dut41 (
    .clk(clk), .rst(rst), .start(s_start), .op_sub(1'b0), .a(s_a), .b(s_b),
    .busy(b41), .done(d41), .sum(sum41), .cout(co41), .ovf(ov41), .zero(z41));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: an accepted op finishes NCH edges later; results hold until the next one.
  int           m_rem = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_sum = '0, p_sum = '0;
  logic         m_cout = 1'b0, m_ovf = 1'b0, m_zero = 1'b0;
  logic         p_cout = 1'b0, p_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem = 0; m_done = 1'b0; m_sum = '0;
      m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1'b1; m_sum = p_sum; m_cout = p_cout;
          m_ovf = p_ovf; m_zero = (p_sum == 0);
        end
      end else if (start) begin
        logic [W:0]   t;
        logic [W-1:0] bb;
        bb     = op_sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, bb} + (W+1)'(op_sub);
        p_sum  = t[W-1:0];
        p_cout = t[W];
        p_ovf  = (a[W-1] == bb[W-1]) && (p_sum[W-1] != a[W-1]);
        m_rem  = NCH;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    chk("busy", busy, m_rem > 0);
    chk("done", done, m_done);
    chk("sum",  sum,  m_sum);
    chk("cout", cout, m_cout);
    chk("ovf",  ovf,  m_ovf);
    chk("zero", zero, m_zero);
  end

  task automatic run_op(input string nm, input logic sub, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] es, input logic ec, input logic eo, input logic ez,
                        input logic disturb);
    int n;
    @(negedge clk);
    start = 1'b1; op_sub = sub; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (disturb && k == 1) begin start = 1'b1; op_sub = ~sub; a = 32'h1234_5678; b = 32'h0F0F_0F0F; end
      if (disturb && k == 2) start = 1'b0;
      if (done) begin n = k; break; end
    end
    chk({nm, "_latency"}, n, NCH);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_ovf"}, ovf, eo);
    chk({nm, "_zero"}, zero, ez);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n44, n41, n;
    #3;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf, zero}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("add_wrap",  1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0);
    run_op("sub_5_7",   1'b1, 32'd5, 32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_7_5",   1'b1, 32'd7, 32'd5,         32'd2,         1'b1, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf",   1'b0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("sub_ovf",   1'b1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("busy_ign",  1'b0, 32'd100, 32'd23,      32'd123,       1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back: start held through the done cycle.
    @(negedge clk);
    start = 1'b1; op_sub = 1'b0; a = 32'd10; b = 32'd20;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin n = k; break; end
    end
    chk("b2b_first_lat", n, NCH);
    chk("b2b_first_sum", sum, 32'd30);
    start = 1'b1; op_sub = 1'b1; a = 32'd50; b = 32'd8;
    @(posedge clk); #1 start = 1'b0;
    chk("b2b_busy_next", busy, 1'b1);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin n = k; break; end
    end
    chk("b2b_second_lat", n, NCH);
    chk("b2b_second_sum", sum, 32'd42);

    // Reset in the second busy cycle aborts the op.
    @(negedge clk);
    start = 1'b1; op_sub = 1'b0; a = 32'hFFFF_0000; b = 32'h0000_1111;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("abort_outs", {busy, done, cout, ovf, zero}, 0);
    chk("abort_sum", sum, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (done) n = k;
    end
    chk("abort_no_done", n, 0);
    run_op("after_rst", 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    // Narrow instances: single-chunk and one-bit-per-cycle.
    @(negedge clk);
    s_start = 1'b1; s_a = 4'hF; s_b = 4'h1;
    @(posedge clk); #1 s_start = 1'b0;
    n44 = 0; n41 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (d44 && n44 == 0) begin
        n44 = k;
        chk("w4c4_sum", sum44, 4'h0); chk("w4c4_cout", co44, 1'b1); chk("w4c4_zero", z44, 1'b1);
      end
      if (d41 && n41 == 0) begin
        n41 = k;
        chk("w4c1_sum", sum41, 4'h0); chk("w4c1_cout", co41, 1'b1); chk("w4c1_zero", z41, 1'b1);
      end
    end
    chk("w4c4_latency", n44, 1);
    chk("w4c1_latency", n41, 4);
    chk("w4_idle", {b44, b41, ov44, ov41}, 0);

    repeat (3) @(posedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
